// File: rtl/ppi_control_logic.sv
// 8255-style PPI control logic: control-word/BSR decode, port write/read strobes,
// and the port A mode-1 strobed handshake (input IBF/STB, output OBF/ACK).
module ppi_control_logic #(
  parameter logic [3:0] RESET_DIR = 4'b1111
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic [1:0] Address,
  input  logic [7:0] DataIn,
  input  logic       StbA_n,
  input  logic       AckA_n,
  output logic [3:0] PortDir,
  output logic [1:0] ModeA,
  output logic       ModeB,
  output logic [2:0] PortWrite,
  output logic       ReadEnable,
  output logic [1:0] ReadSelect,
  output logic       LatchA,
  output logic [7:0] PortCOut,
  output logic       IntrA
);

  typedef enum logic [1:0] {IDLE, FULL, BUSY} hs_state_t;

  hs_state_t state;

  logic cs_q, rd_q, wr_q, stb_q, ack_q;
  logic rd_qq, wr_qq, stb_qq, ack_qq;
  logic int_en_a;
  logic rd_a_pend;

  logic       wr_fire, rd_fall, rd_rise;
  logic       stb_fall, stb_rise, ack_fall, ack_rise;
  logic       mode1, a_in;
  logic [2:0] bsr_bit;
  logic       bsr_inte, bsr_owned;
  logic       port_a_read, port_a_write;

  assign wr_fire  = wr_qq & ~wr_q & ~cs_q;
  assign rd_fall  = rd_qq & ~rd_q;
  assign rd_rise  = ~rd_qq & rd_q;
  assign stb_fall = stb_qq & ~stb_q;
  assign stb_rise = ~stb_qq & stb_q;
  assign ack_fall = ack_qq & ~ack_q;
  assign ack_rise = ~ack_qq & ack_q;

  // Reserved ModeA codes 10/11 fall through to mode 0 behaviour.
  assign mode1 = (ModeA == 2'b01);
  assign a_in  = PortDir[0];

  assign bsr_bit   = DataIn[3:1];
  assign bsr_inte  = mode1 && ((a_in && bsr_bit == 3'd4) || (!a_in && bsr_bit == 3'd6));
  assign bsr_owned = mode1 && (bsr_bit == 3'd3 || bsr_bit == 3'd5 || bsr_bit == 3'd7);

  assign port_a_read  = rd_fall && !cs_q && (Address == 2'b00) && mode1 && a_in;
  assign port_a_write = wr_fire && (Address == 2'b00);

  assign ReadEnable = ~cs_q & ~rd_q & (Address != 2'b11);
  assign ReadSelect = Address;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      stb_q     <= 1'b1;
      ack_q     <= 1'b1;
      rd_qq     <= 1'b1;
      wr_qq     <= 1'b1;
      stb_qq    <= 1'b1;
      ack_qq    <= 1'b1;
      PortDir   <= RESET_DIR;
      ModeA     <= 2'b00;
      ModeB     <= 1'b0;
      PortWrite <= '0;
      LatchA    <= 1'b0;
      PortCOut  <= '0;
      IntrA     <= 1'b0;
      int_en_a  <= 1'b0;
      rd_a_pend <= 1'b0;
      state     <= IDLE;
    end else begin
      cs_q   <= CS_n;
      rd_q   <= RD_n;
      wr_q   <= WR_n;
      stb_q  <= StbA_n;
      ack_q  <= AckA_n;
      rd_qq  <= rd_q;
      wr_qq  <= wr_q;
      stb_qq <= stb_q;
      ack_qq <= ack_q;

      PortWrite <= '0;
      LatchA    <= 1'b0;

      if (wr_fire) begin
        case (Address)
          2'b00:   PortWrite[0] <= 1'b1;
          2'b01:   PortWrite[1] <= 1'b1;
          2'b10:   PortWrite[2] <= 1'b1;
          default: ;
        endcase
      end

      // Strobe/ack edges are applied first; a coincident write below overrides them.
      if (mode1) begin
        if (a_in) begin
          if (port_a_read) begin
            IntrA       <= 1'b0;
            PortCOut[3] <= 1'b0;
            rd_a_pend   <= 1'b1;
          end
          if (rd_rise && rd_a_pend) begin
            rd_a_pend <= 1'b0;
            if (state == FULL) begin
              state       <= IDLE;
              PortCOut[5] <= 1'b0;
            end
          end
          if (stb_fall) begin
            LatchA      <= 1'b1;
            state       <= FULL;
            PortCOut[5] <= 1'b1;
          end
          if (stb_rise && int_en_a) begin
            IntrA       <= 1'b1;
            PortCOut[3] <= 1'b1;
          end
        end else begin
          if (ack_fall) begin
            state       <= IDLE;
            PortCOut[7] <= 1'b1;
          end
          if (ack_rise && int_en_a) begin
            IntrA       <= 1'b1;
            PortCOut[3] <= 1'b1;
          end
          if (port_a_write) begin
            IntrA       <= 1'b0;
            PortCOut[3] <= 1'b0;
            PortCOut[7] <= 1'b0;
            state       <= BUSY;
          end
        end
      end

      if (wr_fire && Address == 2'b11) begin
        if (DataIn[7]) begin
          ModeA      <= DataIn[6:5];
          PortDir[0] <= DataIn[4];
          PortDir[3] <= DataIn[3];
          ModeB      <= DataIn[2];
          PortDir[1] <= DataIn[1];
          PortDir[2] <= DataIn[0];
          PortCOut   <= '0;
          IntrA      <= 1'b0;
          int_en_a   <= 1'b0;
          rd_a_pend  <= 1'b0;
          state      <= IDLE;
        end else if (bsr_inte) begin
          int_en_a <= DataIn[0];
        end else if (!bsr_owned) begin
          PortCOut[bsr_bit] <= DataIn[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ppi_control_logic.sv
// Directed plus randomized transaction bench for ppi_control_logic; a transaction-level
// model of the PPI registers and port A handshake supplies every expected value.
module tb_ppi_control_logic;

  localparam logic [3:0] RDIR = 4'b1010;

  logic       Clock = 1'b0;
  logic       Reset, CS_n, RD_n, WR_n, StbA_n, AckA_n;
  logic [1:0] Address;
  logic [7:0] DataIn;
  logic [3:0] PortDir;
  logic [1:0] ModeA;
  logic       ModeB;
  logic [2:0] PortWrite;
  logic       ReadEnable;
  logic [1:0] ReadSelect;
  logic       LatchA;
  logic [7:0] PortCOut;
  logic       IntrA;

  ppi_control_logic #(.RESET_DIR(RDIR)) dut (
    .Clock(Clock), .Reset(Reset), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .Address(Address), .DataIn(DataIn), .StbA_n(StbA_n), .AckA_n(AckA_n),
    .PortDir(PortDir), .ModeA(ModeA), .ModeB(ModeB), .PortWrite(PortWrite),
    .ReadEnable(ReadEnable), .ReadSelect(ReadSelect), .LatchA(LatchA),
    .PortCOut(PortCOut), .IntrA(IntrA)
  );

  always #5 Clock = ~Clock;

  // Model state
  logic [3:0] m_dir;
  logic [1:0] m_modea;
  logic       m_modeb;
  logic [7:0] m_pc;
  logic       m_intra, m_inten;

  int total = 0;
  int bad   = 0;

  function automatic bit m_mode1();
    return m_modea == 2'b01;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".dir"},   {4'h0, PortDir}, {4'h0, m_dir});
    check({tag, ".modea"}, {6'h0, ModeA},   {6'h0, m_modea});
    check({tag, ".modeb"}, {7'h0, ModeB},   {7'h0, m_modeb});
    check({tag, ".pc"},    PortCOut,        m_pc);
    check({tag, ".intra"}, {7'h0, IntrA},   {7'h0, m_intra});
    check({tag, ".latch"}, {7'h0, LatchA},  8'h00);
  endtask

  task automatic model_reset();
    m_dir = RDIR; m_modea = 2'b00; m_modeb = 1'b0;
    m_pc = 8'h00; m_intra = 1'b0; m_inten = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    int pw [3];
    logic [2:0] b;
    for (int j = 0; j < 3; j++) pw[j] = 0;
    CS_n = 1'b0; Address = a; DataIn = d; WR_n = 1'b0;
    for (int i = 0; i < hold + 3; i++) begin
      if (i == hold) WR_n = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) if (PortWrite[j]) pw[j]++;
    end
    CS_n = 1'b1;
    if (a == 2'b11 && d[7]) begin
      m_modea = d[6:5]; m_dir = {d[3], d[0], d[1], d[4]}; m_modeb = d[2];
      m_pc = 8'h00; m_intra = 1'b0; m_inten = 1'b0;
    end else if (a == 2'b11) begin
      b = d[3:1];
      if (m_mode1() && ((m_dir[0] && b == 3'd4) || (!m_dir[0] && b == 3'd6)))
        m_inten = d[0];
      else if (!(m_mode1() && (b == 3'd3 || b == 3'd5 || b == 3'd7)))
        m_pc[b] = d[0];
    end else if (a == 2'b00 && m_mode1() && !m_dir[0]) begin
      m_intra = 1'b0; m_pc[3] = 1'b0; m_pc[7] = 1'b0;
    end
    for (int j = 0; j < 3; j++)
      check($sformatf("pw%0d_cnt", j), 8'(pw[j]), (a == 2'(j)) ? 8'd1 : 8'd0);
    check_state("write");
  endtask

  task automatic strobe_a(input int hold);
    int lc = 0;
    StbA_n = 1'b0;
    for (int i = 0; i < hold + 1; i++) begin
      tick();
      if (LatchA) lc++;
    end
    if (m_mode1() && m_dir[0]) m_pc[5] = 1'b1;
    check("ibf_low", {7'h0, PortCOut[5]}, {7'h0, m_pc[5]});
    StbA_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (LatchA) lc++;
    end
    if (m_mode1() && m_dir[0] && m_inten) begin
      m_intra = 1'b1; m_pc[3] = 1'b1;
    end
    check("latch_cnt", 8'(lc), (m_mode1() && m_dir[0]) ? 8'd1 : 8'd0);
    check_state("strobe");
  endtask

  task automatic ack_a();
    AckA_n = 1'b0;
    tick(); tick(); tick();
    if (m_mode1() && !m_dir[0]) m_pc[7] = 1'b1;
    check("obf_ack", {7'h0, PortCOut[7]}, {7'h0, m_pc[7]});
    AckA_n = 1'b1;
    tick(); tick(); tick();
    if (m_mode1() && !m_dir[0] && m_inten) begin
      m_intra = 1'b1; m_pc[3] = 1'b1;
    end
    check_state("ack");
  endtask

  task automatic read_port(input logic [1:0] a);
    bit hs;
    hs = m_mode1() && m_dir[0] && a == 2'b00;
    CS_n = 1'b0; RD_n = 1'b0; Address = a;
    tick(); tick();
    check("rd_en", {7'h0, ReadEnable}, (a != 2'b11) ? 8'd1 : 8'd0);
    check("rd_sel", {6'h0, ReadSelect}, {6'h0, a});
    if (hs) begin
      m_intra = 1'b0; m_pc[3] = 1'b0;
    end
    check("rd_intra", {7'h0, IntrA}, {7'h0, m_intra});
    RD_n = 1'b1;
    tick(); tick();
    if (hs) m_pc[5] = 1'b0;
    CS_n = 1'b1;
    tick();
    check("rd_en_idle", {7'h0, ReadEnable}, 8'd0);
    check_state("read");
  endtask

  logic [7:0] d;

  initial begin
    Reset = 1'b1; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    StbA_n = 1'b1; AckA_n = 1'b1; Address = 2'b00; DataIn = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    model_reset();
    tick();
    check_state("reset");
    check("reset_pw", {5'h0, PortWrite}, 8'h00);
    check("reset_re", {7'h0, ReadEnable}, 8'h00);

    cpu_write(2'b11, 8'h80, 1);
    cpu_write(2'b11, 8'h0F, 2);
    check("pc7_set", {7'h0, PortCOut[7]}, 8'd1);
    cpu_write(2'b11, 8'h0E, 1);
    check("pc7_clr", {7'h0, PortCOut[7]}, 8'd0);
    cpu_write(2'b01, 8'h5A, 5);

    // Mode 1 input handshake
    cpu_write(2'b11, 8'hB0, 1);
    cpu_write(2'b11, 8'h09, 1);
    strobe_a(1);
    check("in_intra", {7'h0, IntrA}, 8'd1);
    read_port(2'b00);
    check("in_ibf_clr", {7'h0, PortCOut[5]}, 8'd0);
    read_port(2'b11);

    // Mode 1 output handshake
    cpu_write(2'b11, 8'hA0, 1);
    cpu_write(2'b11, 8'h0D, 1);
    cpu_write(2'b00, 8'h55, 2);
    check("out_obf", {7'h0, PortCOut[7]}, 8'd0);
    ack_a();
    check("out_intra", {7'h0, IntrA}, 8'd1);

    // Reset while FULL
    cpu_write(2'b11, 8'hB0, 1);
    cpu_write(2'b11, 8'h09, 1);
    StbA_n = 1'b0;
    tick(); tick(); tick();
    check("full_before_rst", {7'h0, PortCOut[5]}, 8'd1);
    Reset = 1'b1; StbA_n = 1'b1;
    tick();
    model_reset();
    check_state("mid_reset");
    Reset = 1'b0;
    tick();
    check_state("after_reset");

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: begin
          d = 8'($urandom) | 8'h80;
          if ($urandom_range(0, 2) != 0) d[6:5] = 2'b01;
          cpu_write(2'b11, d, $urandom_range(1, 4));
        end
        1, 2: cpu_write(2'b11, 8'($urandom_range(0, 15)), $urandom_range(1, 4));
        3: cpu_write(2'($urandom_range(0, 2)), 8'($urandom), $urandom_range(1, 4));
        4: strobe_a($urandom_range(1, 3));
        5: ack_a();
        default: read_port(2'($urandom_range(0, 3)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
